// File: rtl/slice_compare_seq.sv
// Sequential unsigned magnitude comparator that walks a 2-bit slice per cycle, MSB slice first.
// Latency: WIDTH/2+1 edges from the accepting edge to done (k+1 with SLICE_CMP_EARLY_EXIT_EN).
// Backpressure: start is only accepted while idle; start during RUN/DONE is ignored.
module slice_compare_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NSL = WIDTH / 2;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             scanned;   // slice 0 has already been folded into the sticky result
  logic             s_gt;
  logic             s_lt;
  logic [1:0]       sa, sb;
  logic             slice_gt, slice_lt;
  logic             decided;
  logic             accept;
  logic             finish;

  // The single 2-bit slice comparator, looking at the slice currently indexed
  always_comb begin
    sa       = a_q[{idx, 1'b0} +: 2];
    sb       = b_q[{idx, 1'b0} +: 2];
    slice_gt = (sa > sb);
    slice_lt = (sa < sb);
  end

  assign decided = s_gt | s_lt;
  assign accept  = (state == IDLE) && start;

`ifdef SLICE_CMP_EARLY_EXIT_EN
  // Leave RUN as soon as a differing slice has fixed the result
  assign finish = scanned | decided;
`else
  // Always examine every slice so latency is data independent
  assign finish = scanned;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = RUN;
      RUN:     if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, slice walk, sticky result and visible result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      scanned <= 1'b0;
      s_gt    <= 1'b0;
      s_lt    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      idx     <= IW'(NSL - 1);
      scanned <= 1'b0;
      s_gt    <= 1'b0;
      s_lt    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else if (state == RUN) begin
      if (finish) begin
        gt <= s_gt;
        lt <= s_lt;
        eq <= ~(s_gt | s_lt);
      end else begin
        // Only the first differing slice may set the sticky result
        if (!decided) begin
          s_gt <= slice_gt;
          s_lt <= slice_lt;
        end
        if (idx == '0) begin
          scanned <= 1'b1;
        end else begin
          idx <= idx - 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
